// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding / hazard detection for an in-order pipeline: tracks the
// writers in flight downstream of issue and picks a forward source or interlocks.
module forwarding_hazard_unit #(
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned SW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dest,
    input  logic                      id_wb_en,
    input  logic                      id_mem_read,
    input  logic                      flush,
    input  logic                      forwarding_en,
    output logic [NUM_SRC*SW-1:0]     sel_src,
    output logic                      stall,
    output logic [15:0]               stall_cnt
);

    logic [DEPTH:1]    valid_q, valid_d;
    logic [DEPTH:1]    wb_q, wb_d;
    logic [DEPTH:1]    mr_q, mr_d;
    logic [REG_AW-1:0] dest_q [1:DEPTH];
    logic [REG_AW-1:0] dest_d [1:DEPTH];
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [DEPTH:1]    hit [NUM_SRC];
    logic              hazard;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                hit[i][k] = id_src_used[i] && valid_q[k] && wb_q[k] &&
                            (dest_q[k] == id_src[i*REG_AW +: REG_AW]);
            end
        end
    end

    always_comb begin
        sel_src = '0;
        hazard  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            // Scan oldest to youngest so the youngest hit overwrites the select.
            for (int unsigned k = DEPTH; k >= 1; k--) begin
                if (hit[i][k]) begin
                    sel_src[i*SW +: SW] = SW'(k);
                end
            end
            if (forwarding_en) begin
                if (hit[i][1] && mr_q[1]) begin
                    hazard = 1'b1;
                end
            end else if (|hit[i]) begin
                hazard = 1'b1;
            end
        end
        if (!forwarding_en) begin
            sel_src = '0;
        end
    end

    assign stall     = id_valid && hazard;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        valid_d    = '0;
        wb_d       = '0;
        mr_d       = '0;
        valid_d[1] = id_valid && !stall && !flush;
        wb_d[1]    = id_wb_en;
        mr_d[1]    = id_mem_read;
        dest_d[1]  = id_dest;
        for (int unsigned k = 2; k <= DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            wb_d[k]    = wb_q[k-1];
            mr_d[k]    = mr_q[k-1];
            dest_d[k]  = dest_q[k-1];
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            wb_q        <= '0;
            mr_q        <= '0;
            stall_cnt_q <= '0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                dest_q[k] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            wb_q        <= wb_d;
            mr_q        <= mr_d;
            stall_cnt_q <= stall_cnt_d;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                dest_q[k] <= dest_d[k];
            end
        end
    end

endmodule

// File: doc/forwarding_hazard_unit.md
FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 4, meaning the register address width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, meaning the number of source operands checked per issued instruction.
REQ-003 The block SHALL have parameter DEPTH, default 3, meaning the tracked in-flight stages: 1=EXE, 2=MEM, 3=WB.
REQ-004 The block SHALL have parameter SW, default $clog2(DEPTH+1), meaning the width of each forward-select field.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port id_valid, input, 1 bit: an instruction is presented for issue.
REQ-008 The block SHALL have port id_src, input, NUM_SRC*REG_AW bits: source register numbers, src i at bits [i*REG_AW +: REG_AW].
REQ-009 The block SHALL have port id_src_used, input, NUM_SRC bits: src i is actually read.
REQ-010 The block SHALL have port id_dest, input, REG_AW bits: destination register number.
REQ-011 The block SHALL have port id_wb_en, input, 1 bit: the instruction writes id_dest.
REQ-012 The block SHALL have port id_mem_read, input, 1 bit: the instruction is a load, with its result available only from MEM onward.
REQ-013 The block SHALL have port flush, input, 1 bit: the issuing instruction is squashed.
REQ-014 The block SHALL have port forwarding_en, input, 1 bit: 1 = forward mode, 0 = full-interlock mode.
REQ-015 The block SHALL have port sel_src, output, NUM_SRC*SW bits: per-source select; 0 = register file, k = result of stage k.
REQ-016 The block SHALL have port stall, output, 1 bit: hold the issue stage this cycle.
REQ-017 The block SHALL have port stall_cnt, output, 16 bits: a saturating count of stalled cycles.

Function
REQ-018 The block SHALL hold a tracking pipeline of DEPTH entries, each entry being {valid, dest, wb_en, mem_read}.
REQ-019 Each clock, entry[k] SHALL load entry[k-1] for k>=2, unconditionally (downstream stages never stall).
REQ-020 Each clock, entry[1] SHALL load the ID fields with valid=1 when id_valid && !stall && !flush, and a bubble (valid=0) otherwise.
REQ-021 An entry SHALL be a hit for src i when id_src_used[i], entry.valid, entry.wb_en, and entry.dest == src i all hold.
REQ-022 In forward mode, sel for src i SHALL be the smallest hit stage k (youngest wins); sel SHALL be 0 if there is no hit.
REQ-023 In forward mode, stall SHALL be 1 when any src hits entry[1] with mem_read=1 (load-use); sel for that source is then don't-care.
REQ-024 In interlock mode, all sel fields SHALL be 0, and stall SHALL be 1 when any src hits any entry.
REQ-025 sel_src and stall SHALL be combinational from the current entries and ID inputs, with zero latency.
REQ-026 stall SHALL be forced to 0 when id_valid=0.
REQ-027 Simultaneous flush and stall SHALL insert a bubble, and flush SHALL NOT clear older entries.
REQ-028 stall_cnt SHALL increment by 1 each clock with stall=1 and saturate at 16'hFFFF.
REQ-029 A toggle of forwarding_en SHALL take effect in the same cycle, with no internal state change.

Reset
REQ-030 While rst=1, all entry.valid bits and stall_cnt SHALL clear immediately, without waiting for clk.
REQ-031 As a consequence, sel_src SHALL be all 0 and stall SHALL be 0 during reset.
REQ-032 A reset asserted mid-stall SHALL discard all in-flight tracking; the first cycle after reset sees no hazards.

Verification
REQ-033 ALU back-to-back, forward mode: issue R1 = ..., then issue with src0=R1 -> sel_src[src0]=1, stall=0.
REQ-034 Load-use: load to R2, then issue with src1=R2 -> stall=1 for 1 cycle; on re-presentation sel_src[src1]=2, stall=0; stall_cnt=1.
REQ-035 Youngest wins: writes to R3 in WB and in MEM, src0=R3 -> sel=2; with the MEM write removed -> sel=3.
REQ-036 Interlock mode: ALU write to R4, dependent follows -> stall=1 for DEPTH cycles, then sel=0, stall=0.
REQ-037 Flush and unused sources: flushed write to R5, then src0=R5 -> sel=0; id_src_used=0 with a matching dest -> sel=0, stall=0.
REQ-038 Reset and saturation: force stall for 70000 cycles -> stall_cnt=16'hFFFF; assert rst between clock edges -> stall_cnt=0 and entries cleared immediately.
